// File: rtl/counter_run_sequencer.sv
// Run sequencer for the gated 8-bit counter: on each start it enables the counter
// clock, issues bursts of count-valid separated by idle gaps, and stops on window
// quota, counter wrap (count-end) or abort, then reports status and the final count.
module counter_run_sequencer #(
  parameter int SETUP_CYCLES = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_burst_len,
  input  logic [CNT_W-1:0] i_gap_len,
  input  logic [CNT_W-1:0] i_num_windows,
  input  logic             i_count_end,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_clk_en,
  output logic             o_count_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_status,
  output logic [CNT_W-1:0] o_windows_done,
  output logic [CNT_W-1:0] o_final_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_COUNT,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_QUOTA = 2'b01;
  localparam logic [1:0] ST_CEND  = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  // Window counter increments saturate instead of wrapping on unbounded runs.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] burst_q, gap_q, nwin_q;
  logic [CNT_W-1:0] burst_eff;
  logic             start_ok;
  logic             in_run;

  // A zero burst length still produces one valid cycle per window.
  assign burst_eff = (burst_q == '0) ? CNT_W'(1) : burst_q;
  assign start_ok  = i_start && !i_abort;
  // States in which count-end can cut the run short.
  assign in_run    = (state_q == S_SETUP) || (state_q == S_COUNT) || (state_q == S_GAP);

  // Next-state, per-state cycle counter, window count and status.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    win_d    = win_q;
    status_d = status_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_ok) begin
          state_d  = S_SETUP;
          win_d    = '0;
          status_d = ST_NONE;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_COUNT;
          cnt_d   = '0;
        end
      end
      S_COUNT: begin
        if (cnt_q == burst_eff - CNT_W'(1)) begin
          cnt_d = '0;
          win_d = sat_inc(win_q);
          if ((nwin_q != '0) && (win_d == nwin_q)) begin
            state_d  = S_DRAIN;
            status_d = ST_QUOTA;
          end else if (gap_q != '0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_COUNT;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == gap_q - CNT_W'(1)) begin
          state_d = S_COUNT;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Count-end overrides window completion; a truncated burst is not counted.
    if (in_run && i_count_end) begin
      state_d  = S_DRAIN;
      cnt_d    = '0;
      win_d    = win_q;
      status_d = ST_CEND;
    end

    // Abort overrides everything except reset and skips the drain phase.
    if ((in_run || (state_q == S_DRAIN)) && i_abort) begin
      state_d  = S_DONE;
      cnt_d    = '0;
      win_d    = win_q;
      status_d = ST_ABORT;
    end
  end

  // Control state and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      win_q         <= '0;
      status_q      <= ST_NONE;
      o_clk_en      <= 1'b0;
      o_count_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_final_count <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      win_q         <= win_d;
      status_q      <= status_d;
      o_clk_en      <= (state_d == S_SETUP) || (state_d == S_COUNT) ||
                       (state_d == S_GAP)   || (state_d == S_DRAIN);
      o_count_valid <= (state_d == S_COUNT);
      o_busy        <= (state_d != S_IDLE);
      o_done        <= (state_d == S_DONE);
      if (state_q == S_DONE) begin
        o_final_count <= i_count;
      end
    end
  end

  // Run configuration is captured only on an accepted start.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && start_ok) begin
      burst_q <= i_burst_len;
      gap_q   <= i_gap_len;
      nwin_q  <= i_num_windows;
    end
  end

  assign o_status       = status_q;
  assign o_windows_done = win_q;

endmodule

// File: tb/tb_counter_run_sequencer.sv
// Bench for counter_run_sequencer: a run schedule (list of per-cycle phases) is
// built from the configuration and edited when count-end or abort interrupts it.
module tb_counter_run_sequencer;

  localparam int SETUP = 4;
  localparam int DRAIN = 2;
  localparam int K_SETUP = 0, K_COUNT = 1, K_GAP = 2, K_DRAIN = 3, K_DONE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, count_end;
  logic [7:0] burst_len, gap_len, num_windows, count;
  logic       clk_en, count_valid, busy, done;
  logic [1:0] status;
  logic [7:0] windows_done, final_count;

  int total = 0;
  int bad   = 0;

  int kq[$];
  bit lq[$];
  int exp_status = 0;
  int exp_win    = 0;
  int exp_final  = 0;

  counter_run_sequencer #(
    .SETUP_CYCLES(SETUP),
    .DRAIN_CYCLES(DRAIN),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_start(start),
    .i_abort(abort),
    .i_burst_len(burst_len),
    .i_gap_len(gap_len),
    .i_num_windows(num_windows),
    .i_count_end(count_end),
    .i_count(count),
    .o_clk_en(clk_en),
    .o_count_valid(count_valid),
    .o_busy(busy),
    .o_done(done),
    .o_status(status),
    .o_windows_done(windows_done),
    .o_final_count(final_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outs(input string ctx, input int en, input int vld,
                            input int bsy, input int dn);
    chk({ctx, ".clk_en"}, int'(clk_en), en);
    chk({ctx, ".valid"}, int'(count_valid), vld);
    chk({ctx, ".busy"}, int'(busy), bsy);
    chk({ctx, ".done"}, int'(done), dn);
    chk({ctx, ".status"}, int'(status), exp_status);
    chk({ctx, ".windows"}, int'(windows_done), exp_win);
    chk({ctx, ".final"}, int'(final_count), exp_final);
  endtask

  task automatic push(input int k, input bit last);
    kq.push_back(k);
    lq.push_back(last);
  endtask

  // Uninterrupted schedule of phases, one entry per clock after the start edge.
  task automatic build(input int burst, input int gap, input int nwin, input int maxwin);
    int nb, nw;
    kq.delete();
    lq.delete();
    repeat (SETUP) push(K_SETUP, 1'b0);
    nb = (burst == 0) ? 1 : burst;
    nw = (nwin == 0) ? maxwin : nwin;
    for (int w = 1; w <= nw; w++) begin
      for (int b = 0; b < nb; b++) push(K_COUNT, b == nb - 1);
      if (gap != 0 && (w < nw || nwin == 0)) repeat (gap) push(K_GAP, 1'b0);
    end
    repeat (DRAIN) push(K_DRAIN, 1'b0);
    push(K_DONE, 1'b0);
  endtask

  // One complete run: start, follow the schedule cycle by cycle, end in IDLE.
  task automatic run_one(input string name, input int burst, input int gap,
                         input int nwin, input int ce_at, input int ab_at,
                         input bit noisy);
    int j, k;
    bit last;
    burst_len   = 8'(burst);
    gap_len     = 8'(gap);
    num_windows = 8'(nwin);
    start       = 1'b1;
    abort       = 1'b0;
    count_end   = 1'b0;
    count       = 8'($urandom);
    tick();
    start      = 1'b0;
    exp_status = 0;
    exp_win    = 0;
    build(burst, gap, nwin, 400);
    j = 0;
    while (kq.size() != 0 && j < 5000) begin
      k    = kq[0];
      last = lq[0];
      check_outs(name, (k != K_DONE) ? 1 : 0, (k == K_COUNT) ? 1 : 0, 1,
                 (k == K_DONE) ? 1 : 0);
      count_end = (j == ce_at);
      abort     = (j == ab_at);
      count     = 8'($urandom);
      if (noisy) begin
        start       = 1'($urandom);
        burst_len   = 8'($urandom);
        gap_len     = 8'($urandom);
        num_windows = 8'($urandom);
      end
      void'(kq.pop_front());
      void'(lq.pop_front());
      if (k == K_DONE) begin
        exp_final = int'(count);
      end else if (abort) begin
        kq.delete();
        lq.delete();
        push(K_DONE, 1'b0);
        exp_status = 3;
      end else if (count_end && k != K_DRAIN) begin
        kq.delete();
        lq.delete();
        repeat (DRAIN) push(K_DRAIN, 1'b0);
        push(K_DONE, 1'b0);
        exp_status = 2;
      end else if (last) begin
        if (exp_win < 255) exp_win++;
        if (nwin != 0 && exp_win == nwin) exp_status = 1;
      end
      tick();
      start     = 1'b0;
      abort     = 1'b0;
      count_end = 1'b0;
      j++;
    end
    if (kq.size() != 0) chk({name, ".timeout"}, 1, 0);
    check_outs({name, ".idle"}, 0, 0, 0, 0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    count_end   = 1'b0;
    burst_len   = 8'd0;
    gap_len     = 8'd0;
    num_windows = 8'd0;
    count       = 8'd0;
    repeat (3) tick();
    check_outs("reset", 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Two windows of three valids with a two-cycle gap; quota stop.
    run_one("quota2", 3, 2, 2, -1, -1, 1'b0);
    chk("quota2.win_final", int'(windows_done), 2);
    chk("quota2.status_final", int'(status), 1);

    // Reset held three cycles while in SETUP.
    burst_len   = 8'd3;
    gap_len     = 8'd1;
    num_windows = 8'd2;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    exp_status = 0;
    exp_win    = 0;
    exp_final  = 0;
    check_outs("midreset", 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_outs("midreset.after", 0, 0, 0, 0);
    run_one("after_reset", 2, 1, 2, -1, -1, 1'b0);

    // Zero burst and zero gap: three back-to-back single valids.
    run_one("zero_len", 0, 0, 3, -1, -1, 1'b0);
    chk("zero_len.status_final", int'(status), 1);

    // Unbounded run, count-end during the second burst.
    run_one("cend", 10, 3, 0, SETUP + 10 + 3 + 4, -1, 1'b0);
    chk("cend.win_final", int'(windows_done), 1);
    chk("cend.status_final", int'(status), 2);

    // Abort while in GAP, with start and config noise during the run.
    run_one("abort_gap", 2, 5, 3, -1, SETUP + 2 + 2, 1'b1);
    chk("abort_gap.status_final", int'(status), 3);

    // Start together with abort in IDLE is ignored.
    start = 1'b1;
    abort = 1'b1;
    burst_len = 8'd1;
    tick();
    check_outs("start_abort", 0, 0, 0, 0);
    tick();
    check_outs("start_abort2", 0, 0, 0, 0);
    start = 1'b0;
    abort = 1'b0;
    tick();

    // Window counter saturates on a long unbounded run.
    run_one("saturate", 0, 0, 0, SETUP + 300, -1, 1'b0);
    chk("saturate.win_final", int'(windows_done), 255);

    // Randomized runs.
    for (int r = 0; r < 14; r++) begin
      int b, g, n, ce, ab;
      b  = $urandom_range(0, 5);
      g  = $urandom_range(0, 3);
      n  = $urandom_range(0, 4);
      ce = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 40);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1;
      if (n == 0 && ce < 0 && ab < 0) ce = $urandom_range(0, 40);
      run_one("rand", b, g, n, ce, ab, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
